clk_gen_nco: RTL and testbench

CLK_GEN_NCO -- requirements
Module: clk_gen_nco

---
 rtl/clk_gen_pkg.sv | 23 ++
 rtl/nco_channel.sv | 118 +++++++++++
 rtl/clk_gen_nco.sv | 85 ++++++++
 tb/tb_clk_gen_nco.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// Shared types and sizing helpers for the multi-channel NCO clock generator.
package clk_gen_pkg;

  typedef enum logic [1:0] {
    OFF     = 2'd0,
    LOCKING = 2'd1,
    RUN     = 2'd2
  } ch_state_t;

  // Lock counter only has to hold 0..LOCK_TICKS-1.
  function automatic int lock_cnt_width(input int lock_ticks);
    int w;
    w = 1;
    while ((1 << w) < lock_ticks) begin
      w = w + 1;
    end
    return w;
  endfunction

  localparam int LOCK_TICKS_MAX = 65535;
  localparam int LOCK_CNT_W     = lock_cnt_width(LOCK_TICKS_MAX);

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: phase accumulator, OFF/LOCKING/RUN sequencing and lock counter.
module nco_channel
  import clk_gen_pkg::*;
#(
  parameter int                   ACC_WIDTH  = 32,
  parameter logic [ACC_WIDTH-1:0] INIT_INCR  = {4'b0001, {(ACC_WIDTH-4){1'b0}}},
  parameter int                   LOCK_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 apply_req,
  input  logic [ACC_WIDTH-1:0] new_incr,
  output logic                 applied,
  output logic                 tick,
  output logic                 clk_out,
  output logic                 locked
);

  localparam int               CNT_W    = lock_cnt_width(LOCK_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TICKS - 1);

  ch_state_t            state_r;
  logic [ACC_WIDTH-1:0] acc_r;
  logic [ACC_WIDTH-1:0] incr_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 tick_r;
  logic                 clk_out_r;
  logic                 locked_r;
  logic [ACC_WIDTH:0]   sum_s;
  logic                 applied_s;

  // Accumulator sum with the carry kept as the top bit.
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, incr_r};
  end

  // An active channel only takes a new increment on its tick so the phase stays continuous.
  always_comb begin
    applied_s = apply_req && ((state_r == OFF) || !en || tick_r);
  end

  // Channel state, accumulator, increment and registered strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= OFF;
      acc_r     <= {ACC_WIDTH{1'b0}};
      incr_r    <= INIT_INCR;
      cnt_r     <= {CNT_W{1'b0}};
      tick_r    <= 1'b0;
      clk_out_r <= 1'b0;
      locked_r  <= 1'b0;
    end else begin
      if (applied_s) begin
        incr_r <= new_incr;
      end else begin
        incr_r <= incr_r;
      end
      if (!en) begin
        state_r   <= OFF;
        acc_r     <= {ACC_WIDTH{1'b0}};
        cnt_r     <= {CNT_W{1'b0}};
        tick_r    <= 1'b0;
        clk_out_r <= 1'b0;
        locked_r  <= 1'b0;
      end else begin
        case (state_r)
          OFF: begin
            state_r   <= LOCKING;
            acc_r     <= {ACC_WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            tick_r    <= 1'b0;
            clk_out_r <= 1'b0;
            locked_r  <= 1'b0;
          end
          LOCKING, RUN: begin
            acc_r     <= sum_s[ACC_WIDTH-1:0];
            tick_r    <= sum_s[ACC_WIDTH];
            clk_out_r <= clk_out_r ^ sum_s[ACC_WIDTH];
            if (applied_s) begin
              state_r  <= LOCKING;
              cnt_r    <= {CNT_W{1'b0}};
              locked_r <= 1'b0;
            end else if ((state_r == LOCKING) && tick_r) begin
              if (cnt_r == CNT_LAST) begin
                state_r  <= RUN;
                cnt_r    <= {CNT_W{1'b0}};
                locked_r <= 1'b1;
              end else begin
                state_r  <= LOCKING;
                cnt_r    <= cnt_r + CNT_W'(1);
                locked_r <= 1'b0;
              end
            end else begin
              state_r  <= state_r;
              cnt_r    <= cnt_r;
              locked_r <= (state_r == RUN);
            end
          end
          default: begin
            state_r   <= OFF;
            acc_r     <= {ACC_WIDTH{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            tick_r    <= 1'b0;
            clk_out_r <= 1'b0;
            locked_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign applied = applied_s;
  assign tick    = tick_r;
  assign clk_out = clk_out_r;
  assign locked  = locked_r;

endmodule

// File: rtl/clk_gen_nco.sv
// Multi-channel NCO clock generator: per-channel NCOs plus a single shared
// pending increment update with a valid/ready handshake.
module clk_gen_nco
  import clk_gen_pkg::*;
#(
  parameter int                   CHANNELS   = 2,
  parameter int                   ACC_WIDTH  = 32,
  parameter logic [ACC_WIDTH-1:0] INIT_INCR  = {4'b0001, {(ACC_WIDTH-4){1'b0}}},
  parameter int                   LOCK_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CHANNELS-1:0]  ch_en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [2:0]           cfg_chan,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  output logic [CHANNELS-1:0]  tick,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  locked
);

  localparam logic [3:0] NUM_CH = 4'(CHANNELS);

  logic                 pend_valid_r;
  logic [2:0]           pend_chan_r;
  logic [ACC_WIDTH-1:0] pend_incr_r;
  logic                 cfg_ready_r;
  logic                 chan_ok_s;
  logic                 any_applied_s;
  logic [CHANNELS-1:0]  applied_s;

  // Out-of-range targets are dropped without occupying the pending slot.
  always_comb begin
    chan_ok_s     = ({1'b0, cfg_chan} < NUM_CH);
    any_applied_s = |applied_s;
  end

  // Single pending update slot and the ready flag that guards it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid_r <= 1'b0;
      pend_chan_r  <= 3'd0;
      pend_incr_r  <= {ACC_WIDTH{1'b0}};
      cfg_ready_r  <= 1'b1;
    end else if (pend_valid_r) begin
      if (any_applied_s) begin
        pend_valid_r <= 1'b0;
        cfg_ready_r  <= 1'b1;
      end else begin
        pend_valid_r <= 1'b1;
        cfg_ready_r  <= 1'b0;
      end
    end else if (cfg_valid && cfg_ready_r && chan_ok_s) begin
      pend_valid_r <= 1'b1;
      pend_chan_r  <= cfg_chan;
      pend_incr_r  <= cfg_incr;
      cfg_ready_r  <= 1'b0;
    end else begin
      pend_valid_r <= 1'b0;
      cfg_ready_r  <= 1'b1;
    end
  end

  assign cfg_ready = cfg_ready_r;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    nco_channel #(
      .ACC_WIDTH  (ACC_WIDTH),
      .INIT_INCR  (INIT_INCR),
      .LOCK_TICKS (LOCK_TICKS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en        (ch_en[gi]),
      .apply_req (pend_valid_r && (pend_chan_r == 3'(gi))),
      .new_incr  (pend_incr_r),
      .applied   (applied_s[gi]),
      .tick      (tick[gi]),
      .clk_out   (clk_out[gi]),
      .locked    (locked[gi])
    );
  end

endmodule

// File: tb/tb_clk_gen_nco.sv
// Self-checking bench for clk_gen_nco: directed scenarios plus random traffic,
// compared every cycle against a phase-sum reference model.
module tb_clk_gen_nco;

  localparam int LOCK_TICKS = 4;
  localparam int MODULUS    = 256;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ch_en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_chan;
  logic [7:0] cfg_incr;
  logic [1:0] tick;
  logic [1:0] clk_out;
  logic [1:0] locked;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_on  = 1'b0;

  clk_gen_nco #(
    .CHANNELS   (2),
    .ACC_WIDTH  (8),
    .INIT_INCR  (8'd64),
    .LOCK_TICKS (LOCK_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ch_en     (ch_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_incr  (cfg_incr),
    .tick      (tick),
    .clk_out   (clk_out),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // Reference model: total phase since enable, ticks are crossings of multiples of 256.
  longint   m_phase[2];
  longint   m_old;
  int       m_incr[2];
  int       m_seen[2];
  bit [1:0] m_act, m_tick, m_clk, m_lock;
  bit       m_ready, m_pend, m_do, m_applied;
  int       m_pchan, m_pincr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 2'b00; m_tick = 2'b00; m_clk = 2'b00; m_lock = 2'b00;
      m_ready = 1'b1; m_pend = 1'b0; m_pchan = 0; m_pincr = 0;
      for (int c = 0; c < 2; c++) begin
        m_phase[c] = 0; m_incr[c] = 64; m_seen[c] = 0;
      end
    end else begin
      m_applied = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_do = m_pend && (m_pchan == c) && (!m_act[c] || !ch_en[c] || m_tick[c]);
        if (!ch_en[c]) begin
          m_act[c] = 1'b0; m_phase[c] = 0; m_seen[c] = 0;
          m_tick[c] = 1'b0; m_clk[c] = 1'b0; m_lock[c] = 1'b0;
        end else if (!m_act[c]) begin
          m_act[c] = 1'b1; m_phase[c] = 0; m_seen[c] = 0;
        end else begin
          if (m_tick[c]) m_seen[c]++;
          m_lock[c]  = (m_seen[c] >= LOCK_TICKS);
          m_old      = m_phase[c];
          m_phase[c] = m_phase[c] + m_incr[c];
          m_tick[c]  = (m_phase[c] / MODULUS) != (m_old / MODULUS);
          m_clk[c]   = m_clk[c] ^ m_tick[c];
        end
        if (m_do) begin
          m_incr[c] = m_pincr; m_seen[c] = 0; m_lock[c] = 1'b0; m_applied = 1'b1;
        end
      end
      if (m_pend) begin
        if (m_applied) begin m_pend = 1'b0; m_ready = 1'b1; end
      end else if (m_ready && cfg_valid && (int'(cfg_chan) < 2)) begin
        m_pend = 1'b1; m_ready = 1'b0; m_pchan = int'(cfg_chan); m_pincr = int'(cfg_incr);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (cmp_on) begin
        check("model_tick",      64'(tick),      64'(m_tick));
        check("model_clk_out",   64'(clk_out),   64'(m_clk));
        check("model_locked",    64'(locked),    64'(m_lock));
        check("model_cfg_ready", 64'(cfg_ready), 64'(m_ready));
      end
    end
  end

  task automatic wait_tick(input int c, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick[c] && n < 300);
    if (!tick[c]) begin
      n_total++;
      $display("FAIL tick_timeout ch%0d: no tick within 300 cycles, one required", c);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!cfg_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) begin
      n_total++;
      $display("FAIL ready_timeout: cfg_ready still 0 after 50 cycles, 1 required");
    end
  endtask

  task automatic cfg_write(input int c, input int v);
    cfg_valid = 1'b1;
    cfg_chan  = 3'(c);
    cfg_incr  = 8'(v);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int n, idx, cnt;
    reset = 1'b1; ch_en = 2'b00; cfg_valid = 1'b0; cfg_chan = 3'd0; cfg_incr = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {tick, clk_out, locked}, 64'h0);
    check("reset_ready", 64'(cfg_ready), 64'h1);
    cmp_on = 1'b1;
    reset = 1'b0; ch_en = 2'b01;

    // Channel 0 at the reset increment: tick every 4 cycles, lock after the 4th tick.
    wait_tick(0, n);
    check("first_tick_clk_high", 64'(clk_out[0]), 64'h1);
    wait_tick(0, n);
    check("tick_gap_64", 64'(n), 64'd4);
    check("second_tick_clk_low", 64'(clk_out[0]), 64'h0);
    wait_tick(0, n);
    wait_tick(0, n);
    check("unlocked_at_4th_tick", 64'(locked[0]), 64'h0);
    @(negedge clk);
    check("locked_after_4th_tick", 64'(locked[0]), 64'h1);
    check("ch1_idle", {tick[1], clk_out[1], locked[1]}, 64'h0);

    // Retune channel 0 while running.
    wait_tick(0, n);
    cfg_write(0, 128);
    check("ready_low_after_accept", 64'(cfg_ready), 64'h0);
    wait_tick(0, n);
    check("ready_low_at_apply_tick", 64'(cfg_ready), 64'h0);
    @(negedge clk);
    check("ready_after_apply", 64'(cfg_ready), 64'h1);
    check("unlocked_after_apply", 64'(locked[0]), 64'h0);
    wait_tick(0, n);
    wait_tick(0, n);
    check("tick_gap_128", 64'(n), 64'd2);
    wait_tick(0, n);
    wait_tick(0, n);
    check("unlocked_at_4th_new_tick", 64'(locked[0]), 64'h0);
    @(negedge clk);
    check("relocked", 64'(locked[0]), 64'h1);

    // Out-of-range channel is ignored.
    cfg_write(5, 1);
    check("bad_chan_ready", 64'(cfg_ready), 64'h1);
    wait_tick(0, n);
    wait_tick(0, n);
    check("bad_chan_no_effect", 64'(n), 64'd2);

    // Pending update on ch1, then drop its enable.
    ch_en = 2'b11;
    repeat (6) @(negedge clk);
    cfg_write(1, 32);
    check("ch1_pending", 64'(cfg_ready), 64'h0);
    ch_en[1] = 1'b0;
    @(negedge clk);
    check("ready_after_drop", 64'(cfg_ready), 64'h1);
    check("ch1_off_outputs", {tick[1], clk_out[1], locked[1]}, 64'h0);
    ch_en[1] = 1'b1;
    wait_tick(1, n);
    wait_tick(1, n);
    check("tick_gap_32", 64'(n), 64'd8);

    // Zero increment stalls the channel; restore through the OFF path.
    cfg_write(0, 0);
    wait_ready();
    repeat (2) @(negedge clk);
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tick[0]) cnt++;
    end
    check("zero_incr_no_ticks", 64'(cnt), 64'd0);
    check("zero_incr_unlocked", 64'(locked[0]), 64'h0);
    cfg_write(0, 64);
    repeat (5) @(negedge clk);
    check("zero_incr_pending", 64'(cfg_ready), 64'h0);
    ch_en[0] = 1'b0;
    @(negedge clk);
    check("ready_after_off_apply", 64'(cfg_ready), 64'h1);
    ch_en[0] = 1'b1;
    wait_tick(0, n);
    wait_tick(0, n);
    check("restored_gap_64", 64'(n), 64'd4);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      if ($urandom_range(15) == 0) begin
        idx = $urandom_range(1);
        ch_en[idx] = ~ch_en[idx];
      end
      if ($urandom_range(5) == 0) begin
        cfg_valid = 1'b1;
        cfg_chan  = ($urandom_range(7) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(1));
        cfg_incr  = ($urandom_range(3) == 0) ? 8'($urandom_range(8)) : 8'($urandom_range(255));
      end
    end

    // Reset in the middle of a pending update.
    @(negedge clk);
    cfg_valid = 1'b0;
    ch_en = 2'b00;
    @(negedge clk);
    wait_ready();
    cfg_write(1, 128);
    wait_ready();
    cfg_write(0, 1);
    wait_ready();
    ch_en = 2'b11;
    repeat (20) @(negedge clk);
    check("pre_reset_ch1_locked", 64'(locked[1]), 64'h1);
    cfg_write(0, 200);
    check("pre_reset_pending", 64'(cfg_ready), 64'h0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", {tick, clk_out, locked}, 64'h0);
    check("async_reset_ready", 64'(cfg_ready), 64'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_tick(0, n);
    wait_tick(0, n);
    check("post_reset_init_incr", 64'(n), 64'd4);
    check("post_reset_ready", 64'(cfg_ready), 64'h1);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
